uart_tx_dual: RTL and testbench

Dual-lane 8N1 UART transmitter: serialises a pair of bytes onto two lines, `tx` and `tx_jiaquan`, with shared bit timing, LSB first. It is the sending end for the dual-lane UART receiver in the FPGA link, which samples `rx`/`rx_jiaquan` at the same rate and produces `message`/`message1`. It sits between the local data source (valid/ready handshake) and the board pins.

---
 rtl/uart_xfh_pkg.sv | 17 +
 rtl/uart_baud_cnt.sv | 44 ++++
 rtl/uart_tx_dual.sv | 154 +++++++++++++++
 tb/tb_uart_tx_dual.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_xfh_pkg.sv
// Shared definitions for the dual-lane UART link (transmitter and receiver).
//   uart_state_e      : frame-level state shared by TX and RX
//   UART_CLKS_PER_BIT : default bit period, 100 MHz system clock at 9600 baud
//   UART_DATA_W       : payload width per lane
package uart_xfh_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_CLKS_PER_BIT = 10416;
  localparam int UART_DATA_W       = 8;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled, wraps to 0 and
// flags the terminal-count cycle with a one-cycle tick.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to 0 (takes priority over en)
//   en       : count enable
//   cnt      : current count
//   tick     : high in the terminal-count cycle (bit boundary)
module uart_baud_cnt
  import uart_xfh_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign tick = en && !clr && (cnt_q == TERM);

endmodule

// File: rtl/uart_tx_dual.sv
// Dual-lane 8N1 UART transmitter. Two bytes are sent LSB first in lockstep on
// tx (lane 0) and tx_jiaquan (lane 1) with one shared bit timer.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   data, data1      : byte pair for lane 0 / lane 1
//   valid, ready     : input handshake; a pair is taken when both are high
//                      at a rising edge. ready is high only in IDLE, so
//                      valid during a frame is ignored and the source must
//                      hold valid (and the pair) until ready.
//   tx, tx_jiaquan   : registered serial lines, idle high
//   busy             : frame in progress (never high together with ready)
//   done             : one-cycle pulse in the last stop-bit cycle
module uart_tx_dual
  import uart_xfh_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] data,
  input  logic [UART_DATA_W-1:0] data1,
  input  logic                   valid,
  output logic                   ready,
  output logic                   tx,
  output logic                   tx_jiaquan,
  output logic                   busy,
  output logic                   done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // done is registered, so it is set one cycle ahead of terminal count.
  localparam logic [CNT_W-1:0] PRE_TERM = CNT_W'(CLKS_PER_BIT - 2);

  uart_state_e            state_q, state_d;
  logic [UART_DATA_W-1:0] shift0_q, shift0_d;
  logic [UART_DATA_W-1:0] shift1_q, shift1_d;
  logic [2:0]             idx_q, idx_d;
  logic                   stop_q, stop_d;
  logic                   tx_q, tx_d;
  logic                   tx1_q, tx1_d;
  logic                   done_q, done_d;

  logic             accept;
  logic             last_stop;
  logic [CNT_W-1:0] baud_cnt;
  logic             baud_tick;

  assign accept    = (state_q == IDLE) && valid;
  // With one stop bit the first stop period is already the last one.
  assign last_stop = (STOP_BITS == 1) || stop_q;

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (state_q != IDLE),
    .cnt  (baud_cnt),
    .tick (baud_tick)
  );

  always_comb begin
    state_d  = state_q;
    shift0_d = shift0_q;
    shift1_d = shift1_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    tx_d     = tx_q;
    tx1_d    = tx1_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        tx1_d = 1'b1;
        if (accept) begin
          shift0_d = data;
          shift1_d = data1;
          idx_d    = '0;
          stop_d   = 1'b0;
          tx_d     = 1'b0;
          tx1_d    = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_tick) begin
          idx_d   = '0;
          tx_d    = shift0_q[0];
          tx1_d   = shift1_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            tx1_d   = 1'b1;
            stop_d  = 1'b0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shift0_q[idx_d];
            tx1_d = shift1_q[idx_d];
          end
        end
      end
      STOP: begin
        if (last_stop && (baud_cnt == PRE_TERM)) done_d = 1'b1;
        if (baud_tick) begin
          if (last_stop) state_d = IDLE;
          else           stop_d  = 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        tx1_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shift0_q <= '0;
      shift1_q <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      tx_q     <= 1'b1;
      tx1_q    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift0_q <= shift0_d;
      shift1_q <= shift1_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      tx_q     <= tx_d;
      tx1_q    <= tx1_d;
      done_q   <= done_d;
    end
  end

  assign tx         = tx_q;
  assign tx_jiaquan = tx1_q;
  assign done       = done_q;
  assign ready      = (state_q == IDLE);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_dual.sv
// Bench for uart_tx_dual. Instance a: 1 stop bit, instance b: 2 stop bits,
// both 16 clocks per bit. Expected pin values per cycle are built from the
// frame rules (start 0, 8 data bits LSB first, stop 1s) into exp_q and
// compared one entry per clock on the falling edge.
module tb_uart_tx_dual;

  localparam int CPB = 16;
  // Observation vector {ready, done, busy, tx_jiaquan, tx}
  localparam logic [4:0] IDLE_OBS = 5'b10011;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] data_a = '0, data1_a = '0, data_b = '0, data1_b = '0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       ready_a, tx_a, tx1_a, busy_a, done_a;
  logic       ready_b, tx_b, tx1_b, busy_b, done_b;

  uart_tx_dual #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .rst(rst), .data(data_a), .data1(data1_a), .valid(valid_a),
    .ready(ready_a), .tx(tx_a), .tx_jiaquan(tx1_a), .busy(busy_a), .done(done_a)
  );

  uart_tx_dual #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .data(data_b), .data1(data1_b), .valid(valid_b),
    .ready(ready_b), .tx(tx_b), .tx_jiaquan(tx1_b), .busy(busy_b), .done(done_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int done_seen_a = 0, done_seen_b = 0;
  int frames_a = 0, frames_b = 0;
  logic [4:0] exp_q[$];

  always @(negedge clk) begin
    if (done_a) done_seen_a++;
    if (done_b) done_seen_b++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] obs(input int which);
    if (which == 0) return {ready_a, done_a, busy_a, tx1_a, tx_a};
    return {ready_b, done_b, busy_b, tx1_b, tx_b};
  endfunction

  // Reference: pin values k cycles after the accept edge (k = 1 is the
  // first start-bit cycle).
  function automatic logic [4:0] exp_cycle(input int sb, input logic [7:0] d0,
                                           input logic [7:0] d1, input int k);
    int   b;
    logic l0, l1;
    b = (k - 1) / CPB;
    if (b == 0) begin
      l0 = 1'b0; l1 = 1'b0;
    end else if (b <= 8) begin
      l0 = d0[3'(b - 1)]; l1 = d1[3'(b - 1)];
    end else begin
      l0 = 1'b1; l1 = 1'b1;
    end
    return {1'b0, (k == (9 + sb) * CPB), 1'b1, l1, l0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int which, input logic v, input logic [7:0] d0, input logic [7:0] d1);
    if (which == 0) begin
      valid_a = v; data_a = d0; data1_a = d1;
    end else begin
      valid_b = v; data_b = d0; data1_b = d1;
    end
  endtask

  // upto = 0 pushes the whole frame, otherwise only cycles 1..upto.
  task automatic push_frame(input int sb, input logic [7:0] d0, input logic [7:0] d1, input int upto);
    int last;
    last = (upto == 0) ? (9 + sb) * CPB : upto;
    for (int k = 1; k <= last; k++) exp_q.push_back(exp_cycle(sb, d0, d1, k));
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(IDLE_OBS);
  endtask

  // One comparison per clock until exp_q is empty. drop releases valid in
  // the first cycle; pulse_at raises valid with 8'h11 for one cycle.
  task automatic drain(input int which, input string tag, input bit drop, input int pulse_at);
    int k;
    logic [4:0] e;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      k++;
      if (drop && k == 1) drive(which, 1'b0, 8'h00, 8'h00);
      if (pulse_at != 0 && k == pulse_at)     drive(which, 1'b1, 8'h11, 8'h11);
      if (pulse_at != 0 && k == pulse_at + 1) drive(which, 1'b0, 8'h11, 8'h11);
      e = exp_q.pop_front();
      check_eq($sformatf("%s[%0d]", tag, k), 32'(obs(which)), 32'(e));
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge
  // with the DUT idle again.
  task automatic send(input int which, input int sb, input logic [7:0] d0, input logic [7:0] d1,
                      input string tag, input int pulse_at, input int gap);
    drive(which, 1'b1, d0, d1);
    push_frame(sb, d0, d1, 0);
    drain(which, tag, 1'b1, pulse_at);
    push_idle(1 + gap);
    drain(which, {tag, "_idle"}, 1'b0, 0);
    if (which == 0) frames_a++;
    else            frames_b++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] r0, r1;

    // Reset held with valid high: nothing may be accepted.
    drive(0, 1'b1, 8'hFF, 8'hFF);
    drive(1, 1'b1, 8'hFF, 8'hFF);
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_a", 32'(obs(0)), 32'(IDLE_OBS));
      check_eq("rst_b", 32'(obs(1)), 32'(IDLE_OBS));
    end
    rst = 1'b0;
    drive(0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 8'h00, 8'h00);
    push_idle(2);
    drain(0, "post_rst_a", 1'b0, 0);
    check_eq("post_rst_b", 32'(obs(1)), 32'(IDLE_OBS));

    // Single frame.
    send(0, 1, 8'hA5, 8'h3C, "single", 0, 0);
    check_eq("done_cnt_single", 32'(done_seen_a), 32'(frames_a));

    // Back-to-back with valid held high: one idle cycle between frames.
    drive(0, 1'b1, 8'h00, 8'hFF);
    push_frame(1, 8'h00, 8'hFF, 0);
    push_idle(1);
    drain(0, "b2b0", 1'b0, 0);
    drive(0, 1'b1, 8'hFF, 8'h00);
    push_frame(1, 8'hFF, 8'h00, 0);
    drain(0, "b2b1", 1'b1, 0);
    push_idle(1);
    drain(0, "b2b_idle", 1'b0, 0);
    frames_a += 2;
    check_eq("done_cnt_b2b", 32'(done_seen_a), 32'(frames_a));

    // valid pulse mid-frame is ignored.
    send(0, 1, 8'h55, 8'hAA, "ignore", 40, 0);

    // Reset during data bit 3 (both lanes low there).
    drive(0, 1'b1, 8'h96, 8'h21);
    push_frame(1, 8'h96, 8'h21, 69);
    drain(0, "abort", 1'b1, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_eq("rst_async", 32'(obs(0)), 32'(IDLE_OBS));
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_hold", 32'(obs(0)), 32'(IDLE_OBS));
    end
    rst = 1'b0;
    send(0, 1, 8'hC3, 8'h3C, "after_rst", 0, 0);
    check_eq("done_cnt_abort", 32'(done_seen_a), 32'(frames_a));

    // Random pairs, random idle gaps.
    for (int i = 0; i < 3; i++) begin
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      send(0, 1, r0, r1, $sformatf("rand_a%0d", i), 0, $urandom_range(0, 3));
    end

    // Two stop bits.
    send(1, 2, 8'h7E, 8'h81, "stop2", 0, 0);
    for (int i = 0; i < 3; i++) begin
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      send(1, 2, r0, r1, $sformatf("rand_b%0d", i), $urandom_range(0, 1) * 60, $urandom_range(0, 2));
    end

    check_eq("done_cnt_a", 32'(done_seen_a), 32'(frames_a));
    check_eq("done_cnt_b", 32'(done_seen_b), 32'(frames_b));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
